// File: rtl/mouse_transmitter_if.sv
// Bundle of PS/2 line and command handshake signals between the mouse master
// and the host-to-device transmitter.
interface mouse_transmitter_if;
  logic       clk_mouse_in;
  logic       data_mouse_in;
  logic       clk_mouse_out_en;
  logic       data_mouse_out;
  logic       data_mouse_out_en;
  logic       send_byte;
  logic [7:0] byte_to_send;
  logic       byte_sent;
  logic [1:0] send_error_code;
  logic       busy;

  // master: the side that requests transfers and owns the physical lines
  modport master (
    output send_byte, byte_to_send, clk_mouse_in, data_mouse_in,
    input  clk_mouse_out_en, data_mouse_out, data_mouse_out_en,
    input  byte_sent, send_error_code, busy
  );

  modport slave (
    input  send_byte, byte_to_send, clk_mouse_in, data_mouse_in,
    output clk_mouse_out_en, data_mouse_out, data_mouse_out_en,
    output byte_sent, send_error_code, busy
  );
endinterface

// File: rtl/mouse_transmitter.sv
// PS/2 host-to-device transmitter: request-to-send, 8 data bits LSB first,
// odd parity, stop, then device acknowledge check with an overall timeout.
module mouse_transmitter #(
  parameter int HOLD_CYCLES    = 10000,
  parameter int SETUP_CYCLES   = 20,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input logic              clk,
  input logic              reset,
  mouse_transmitter_if.slave bus
);

  localparam int WAIT_MAX = (HOLD_CYCLES > SETUP_CYCLES) ? HOLD_CYCLES : SETUP_CYCLES;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam int TOUT_W   = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    IDLE, HOLD_CLK, START, RELEASE_CLK, SEND_BITS,
    SEND_STOP, WAIT_ACK, WAIT_IDLE, DONE
  } state_t;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  state_t              state_q, state_n;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_n;
  logic [TOUT_W-1:0]   tout_q, tout_n;
  logic [3:0]          bit_cnt_q, bit_cnt_n;
  logic [8:0]          shift_q, shift_n;
  logic                clk_en_q, clk_en_n;
  logic                data_out_q, data_out_n;
  logic                data_en_q, data_en_n;
  logic                byte_sent_q, byte_sent_n;
  logic [1:0]          code_q, code_n;
  logic                busy_q, busy_n;
  logic                timeout;
  logic                fall;

  // synchroniser stages; p2 holds the previous synchronised clock for edge detect
  logic ps2_clk_p0, ps2_clk_p1, ps2_clk_p2;
  logic ps2_dat_p0, ps2_dat_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      ps2_clk_p0 <= 1'b1;
      ps2_clk_p1 <= 1'b1;
      ps2_clk_p2 <= 1'b1;
      ps2_dat_p0 <= 1'b1;
      ps2_dat_p1 <= 1'b1;
    end else begin
      ps2_clk_p0 <= bus.clk_mouse_in;
      ps2_clk_p1 <= ps2_clk_p0;
      ps2_clk_p2 <= ps2_clk_p1;
      ps2_dat_p0 <= bus.data_mouse_in;
      ps2_dat_p1 <= ps2_dat_p0;
    end
  end

  assign fall = ps2_clk_p2 & ~ps2_clk_p1;

  always_comb begin
    state_n    = state_q;
    wait_cnt_n = wait_cnt_q;
    tout_n     = tout_q;
    bit_cnt_n  = bit_cnt_q;
    shift_n    = shift_q;
    data_out_n = data_out_q;
    data_en_n  = data_en_q;
    code_n     = code_q;
    timeout    = 1'b0;

    if (state_q inside {RELEASE_CLK, SEND_BITS, SEND_STOP, WAIT_ACK, WAIT_IDLE}) begin
      tout_n  = tout_q + TOUT_W'(1);
      timeout = (tout_n == TOUT_W'(TIMEOUT_CYCLES));
    end

    case (state_q)
      IDLE: begin
        data_en_n  = 1'b0;
        data_out_n = 1'b1;
        if (bus.send_byte) begin
          shift_n    = {odd_parity(bus.byte_to_send), bus.byte_to_send};
          code_n     = 2'b00;
          wait_cnt_n = '0;
          state_n    = HOLD_CLK;
        end
      end
      HOLD_CLK: begin
        if (wait_cnt_q == WAIT_W'(HOLD_CYCLES - 1)) begin
          wait_cnt_n = '0;
          data_en_n  = 1'b1;
          data_out_n = 1'b0;
          state_n    = START;
        end else begin
          wait_cnt_n = wait_cnt_q + WAIT_W'(1);
        end
      end
      START: begin
        if (wait_cnt_q == WAIT_W'(SETUP_CYCLES - 1)) begin
          tout_n    = '0;
          bit_cnt_n = '0;
          state_n   = RELEASE_CLK;
        end else begin
          wait_cnt_n = wait_cnt_q + WAIT_W'(1);
        end
      end
      RELEASE_CLK: state_n = SEND_BITS;
      SEND_BITS: begin
        // parity sits in shift_q[8], so nine shifts cover data and parity
        if (fall) begin
          data_out_n = shift_q[0];
          shift_n    = {1'b1, shift_q[8:1]};
          bit_cnt_n  = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd8) state_n = SEND_STOP;
        end
      end
      SEND_STOP: begin
        if (fall) begin
          data_en_n  = 1'b0;
          data_out_n = 1'b1;
          state_n    = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (fall) begin
          if (ps2_dat_p1) code_n = 2'b01;
          state_n = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (ps2_clk_p1 && ps2_dat_p1) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // timeout overrides whatever the edge logic decided this cycle
    if (timeout) begin
      state_n    = DONE;
      code_n     = 2'b10;
      data_en_n  = 1'b0;
      data_out_n = 1'b1;
      shift_n    = shift_q;
      bit_cnt_n  = bit_cnt_q;
    end

    clk_en_n    = (state_n == HOLD_CLK) || (state_n == START);
    byte_sent_n = (state_n == DONE);
    busy_n      = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      tout_q      <= '0;
      bit_cnt_q   <= '0;
      clk_en_q    <= 1'b0;
      data_out_q  <= 1'b1;
      data_en_q   <= 1'b0;
      byte_sent_q <= 1'b0;
      code_q      <= 2'b00;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_n;
      wait_cnt_q  <= wait_cnt_n;
      tout_q      <= tout_n;
      bit_cnt_q   <= bit_cnt_n;
      clk_en_q    <= clk_en_n;
      data_out_q  <= data_out_n;
      data_en_q   <= data_en_n;
      byte_sent_q <= byte_sent_n;
      code_q      <= code_n;
      busy_q      <= busy_n;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_n;
  end

  assign bus.clk_mouse_out_en  = clk_en_q;
  assign bus.data_mouse_out    = data_out_q;
  assign bus.data_mouse_out_en = data_en_q;
  assign bus.byte_sent         = byte_sent_q;
  assign bus.send_error_code   = code_q;
  assign bus.busy              = busy_q;

endmodule

// File: tb/tb_mouse_transmitter.sv
// Directed bench for mouse_transmitter with a simple PS/2 mouse line model.
module tb_mouse_transmitter;
  localparam int HOLD  = 20;
  localparam int SETUP = 4;
  localparam int TOUT  = 3000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mouse_transmitter_if bus();

  logic dev_clk  = 1'b1;
  logic dev_data = 1'b1;

  // open-drain lines: either side can only pull low
  assign bus.clk_mouse_in  = dev_clk & ~bus.clk_mouse_out_en;
  assign bus.data_mouse_in = dev_data & ~(bus.data_mouse_out_en & ~bus.data_mouse_out);

  mouse_transmitter #(
    .HOLD_CYCLES(HOLD), .SETUP_CYCLES(SETUP), .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  int sent_cnt = 0;

  always @(negedge clk) if (bus.byte_sent === 1'b1) sent_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_send(input logic [7:0] b);
    @(negedge clk);
    bus.byte_to_send = b;
    bus.send_byte    = 1'b1;
    @(negedge clk);
    bus.send_byte    = 1'b0;
  endtask

  // counts clock-pull cycles and start-bit setup cycles until the clock is released
  task automatic wait_release(output int hc, output int sc, output bit ok);
    ok = 0; hc = 0; sc = 0;
    for (int i = 0; i < HOLD + SETUP + 20; i++) begin
      if (bus.clk_mouse_out_en) begin
        hc++;
        if (bus.data_mouse_out_en && !bus.data_mouse_out) sc++;
      end else if (hc > 0) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic device_clock(input int n_edges, input bit ack, input bit intrude,
                              output logic [8:0] frame, output logic stop_ok);
    frame = '0;
    stop_ok = 1'b0;
    for (int i = 0; i < n_edges; i++) begin
      cycles(10);
      if (i == 10) dev_data = ack;
      dev_clk = 1'b0;
      cycles(10);
      if (i < 9) frame[i] = bus.data_mouse_in;
      if (i == 9) stop_ok = !bus.data_mouse_out_en && bus.data_mouse_in;
      if (intrude && i == 3) begin
        bus.byte_to_send = 8'hAA;
        bus.send_byte    = 1'b1;
        @(negedge clk);
        bus.send_byte    = 1'b0;
      end
      dev_clk = 1'b1;
      if (i == 10) dev_data = 1'b1;
    end
  endtask

  task automatic wait_sent(input int base, input int limit, output int elapsed, output bit ok);
    ok = 0;
    elapsed = 0;
    for (int i = 0; i < limit; i++) begin
      if (sent_cnt > base) begin
        ok = 1;
        break;
      end
      elapsed++;
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [7:0] b;
    bit         ack;
    bit         intrude;
    logic [8:0] frame;
    logic [1:0] code;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    int hc, sc, base, el;
    bit ok;
    logic [8:0] frame;
    logic stop_ok;
    base = sent_cnt;
    start_send(v.b);
    check({tag, " busy_after_accept"}, 32'(bus.busy), 32'd1);
    wait_release(hc, sc, ok);
    check({tag, " release_seen"}, 32'(ok), 32'd1);
    check({tag, " clk_hold_cycles"}, hc, HOLD + SETUP);
    check({tag, " start_setup_cycles"}, sc, SETUP);
    device_clock(11, v.ack, v.intrude, frame, stop_ok);
    check({tag, " frame_bits"}, 32'(frame), 32'(v.frame));
    check({tag, " stop_released"}, 32'(stop_ok), 32'd1);
    wait_sent(base, 50, el, ok);
    check({tag, " byte_sent_seen"}, 32'(ok), 32'd1);
    cycles(5);
    check({tag, " byte_sent_once"}, sent_cnt - base, 32'd1);
    check({tag, " error_code"}, 32'(bus.send_error_code), 32'(v.code));
    check({tag, " busy_low"}, 32'(bus.busy), 32'd0);
    check({tag, " lines_released"},
          32'({bus.clk_mouse_out_en, bus.data_mouse_out_en}), 32'd0);
  endtask

  vec_t vecs[6];

  initial begin
    int hc, sc, base, el;
    bit ok;
    logic [8:0] frame;
    logic stop_ok;

    vecs[0] = '{8'hF4, 1'b0, 1'b0, 9'h0F4, 2'b00};
    vecs[1] = '{8'hFF, 1'b0, 1'b0, 9'h1FF, 2'b00};
    vecs[2] = '{8'h00, 1'b0, 1'b0, 9'h100, 2'b00};
    vecs[3] = '{8'hA5, 1'b1, 1'b0, 9'h1A5, 2'b01};
    vecs[4] = '{8'hF4, 1'b0, 1'b1, 9'h0F4, 2'b00};
    vecs[5] = '{8'h37, 1'b0, 1'b0, 9'h037, 2'b00};

    reset = 1'b1;
    bus.send_byte = 1'b0;
    bus.byte_to_send = 8'h00;
    cycles(3);
    reset = 1'b0;
    cycles(2);
    check("rst clk_en", 32'(bus.clk_mouse_out_en), 32'd0);
    check("rst data_out", 32'(bus.data_mouse_out), 32'd1);
    check("rst data_en", 32'(bus.data_mouse_out_en), 32'd0);
    check("rst byte_sent", 32'(bus.byte_sent), 32'd0);
    check("rst code", 32'(bus.send_error_code), 32'd0);
    check("rst busy", 32'(bus.busy), 32'd0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // device never clocks after release
    base = sent_cnt;
    start_send(8'hF4);
    wait_release(hc, sc, ok);
    check("tout release_seen", 32'(ok), 32'd1);
    wait_sent(base, TOUT + 100, el, ok);
    check("tout byte_sent_seen", 32'(ok), 32'd1);
    check("tout latency_in_window", 32'(el >= TOUT - 2 && el <= TOUT + 3), 32'd1);
    check("tout code", 32'(bus.send_error_code), 32'd2);
    check("tout lines_released",
          32'({bus.clk_mouse_out_en, bus.data_mouse_out_en, bus.data_mouse_out}), 32'd1);
    cycles(3);
    check("tout busy_low", 32'(bus.busy), 32'd0);
    check("tout byte_sent_once", sent_cnt - base, 32'd1);

    // reset after bit 3 has gone out
    base = sent_cnt;
    start_send(8'hF4);
    wait_release(hc, sc, ok);
    device_clock(4, 1'b0, 1'b0, frame, stop_ok);
    check("midrst bits_0_3", 32'(frame[3:0]), 32'h4);
    check("midrst still_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst enables", 32'({bus.clk_mouse_out_en, bus.data_mouse_out_en}), 32'd0);
    check("midrst busy", 32'(bus.busy), 32'd0);
    cycles(3);
    check("midrst no_byte_sent", sent_cnt - base, 32'd0);
    run_vec(vecs[0], "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/mouse_transmitter.md
# mouse_transmitter

Host-to-device PS/2 transmitter for the mouse interface: sends one command byte (e.g. 0xFF reset, 0xF4 enable reporting) to the mouse. It is the transmit partner of the mouse byte receiver and sits beside it under the mouse master state machine. It performs the PS/2 request-to-send sequence, shifts out 8 data bits, odd parity and stop on device-generated clock edges, and checks the device acknowledge. Both PS/2 lines are open-drain: this block only drives low through enables; the top level ties the driven value to 0 and releases the line when the enable is 0.

## Interface
- HOLD_CYCLES, 10000: system-clock cycles the PS/2 clock is held low for request-to-send (100 us at 100 MHz).
- SETUP_CYCLES, 20: cycles data is held low before the clock is released.
- TIMEOUT_CYCLES, 2000000: cycles allowed from clock release to acknowledge-complete (20 ms at 100 MHz).
- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- CLK_MOUSE_IN  in  1  PS/2 clock line, read back.
- DATA_MOUSE_IN  in  1  PS/2 data line, read back.
- CLK_MOUSE_OUT_EN  out  1  1 = pull PS/2 clock low.
- DATA_MOUSE_OUT  out  1  data value presented when enabled (0 or 1).
- DATA_MOUSE_OUT_EN  out  1  1 = drive data line with DATA_MOUSE_OUT.
- SEND_BYTE  in  1  request; sampled only in IDLE.
- BYTE_TO_SEND  in  8  byte to transmit; latched with SEND_BYTE.
- BYTE_SENT  out  1  one-cycle pulse at end of transfer, success or failure.
- SEND_ERROR_CODE  out  2  00 ok, 01 no acknowledge, 10 timeout; valid with BYTE_SENT and held until the next request.
- BUSY  out  1  high in every state except IDLE.

## Operation
- CLK_MOUSE_IN and DATA_MOUSE_IN pass through a two-flop synchroniser. A falling edge is: previous synchronised clock 1 and current 0.
- States: IDLE, HOLD_CLK, START, RELEASE_CLK, SEND_BITS, SEND_STOP, WAIT_ACK, WAIT_IDLE, DONE.
- IDLE: all enables 0. SEND_BYTE=1 latches BYTE_TO_SEND into the shift register, computes parity = XNOR-reduce of the byte (odd parity), clears SEND_ERROR_CODE, and goes to HOLD_CLK.
- HOLD_CLK: CLK_MOUSE_OUT_EN=1 for HOLD_CYCLES cycles, then go to START.
- START: CLK_MOUSE_OUT_EN=1, DATA_MOUSE_OUT_EN=1, DATA_MOUSE_OUT=0 (start bit) for SETUP_CYCLES cycles, then go to RELEASE_CLK.
- RELEASE_CLK: CLK_MOUSE_OUT_EN=0; data stays driven 0. Bit counter is cleared and the timeout counter starts. Go to SEND_BITS next cycle.
- SEND_BITS: on each falling edge, DATA_MOUSE_OUT takes the next bit: data bits 0..7 (LSB first), then parity. Counter 0..8. After the parity edge, go to SEND_STOP.
- SEND_STOP: on the next falling edge, DATA_MOUSE_OUT_EN goes to 0 (line released, stop bit = 1); go to WAIT_ACK.
- WAIT_ACK: on the next falling edge, sample synchronised data. 0 = ack; 1 = set code 01. Go to WAIT_IDLE.
- WAIT_IDLE: wait until synchronised clock and data are both 1, then go to DONE.
- DONE: BYTE_SENT=1 for one cycle, then go to IDLE.
- Timeout: if the counter reaches TIMEOUT_CYCLES in any state from RELEASE_CLK through WAIT_IDLE, set code 10, release all lines, and go to DONE. Timeout takes priority over an edge in the same cycle.
- SEND_BYTE while BUSY is ignored; no queueing.
- RESET in any state, including mid-transfer: next cycle the block is in IDLE with all lines released.

## Timing
- Reset values: CLK_MOUSE_OUT_EN=0, DATA_MOUSE_OUT=1, DATA_MOUSE_OUT_EN=0, BYTE_SENT=0, SEND_ERROR_CODE=00, BUSY=0.
- Outputs are registered. Clock pull starts one cycle after SEND_BYTE is sampled.
- Data changes 3 system cycles after a falling edge on the pin (2 synchroniser stages plus 1 output register). This is well inside the roughly 30 us clock-low window.
- Eleven device falling edges per transfer: 9 bits + stop + ack.
- BUSY rises the cycle after acceptance and falls the cycle after the BYTE_SENT pulse.

## Test plan
- Send 0xF4 with a mouse model that acks: drive values on successive edges are 0,0,1,0,1,1,1,1 then parity 0; data released; BYTE_SENT pulses once; code 00.
- Send 0xFF, then 0x00: parity bit is 1 in both cases; both transfers complete with code 00.
- Model drives ack=1: BYTE_SENT pulses with code 01; lines released.
- Model never clocks after release: after TIMEOUT_CYCLES, BYTE_SENT pulses with code 10; CLK_MOUSE_OUT_EN=0 and DATA_MOUSE_OUT_EN=0.
- Assert RESET after bit 3: next cycle all enables are 0 and BUSY=0; a following send of 0xF4 succeeds.
- Pulse SEND_BYTE=1 with 0xAA during an active 0xF4 transfer: the bits transmitted remain those of 0xF4; exactly one BYTE_SENT pulse.
